// File: rtl/bcd_time_counter_pkg.sv
// Shared types and constants for the BCD time-of-day counter.
// bcd_inc steps a two-digit BCD field by one and wraps at (max_h, max_l).
package bcd_time_counter_pkg;

   typedef logic [3:0] bcd_t;

   typedef struct packed {
      bcd_t hi;
      bcd_t lo;
   } bcd_pair_t;

   localparam bcd_t SEC_MAX_H     = 4'd5;
   localparam bcd_t MIN_MAX_H     = 4'd5;
   localparam bcd_t HR_MAX_H      = 4'd2;
   localparam bcd_t HR_MAX_L_AT_2 = 4'd3;
   localparam bcd_t DIGIT_MAX     = 4'd9;

   function automatic bcd_pair_t bcd_inc(input bcd_pair_t v, input bcd_t max_h,
                                         input bcd_t max_l);
      bcd_pair_t r;
      if (v.hi == max_h && v.lo == max_l) begin
         r = '0;
      end else if (v.lo == DIGIT_MAX) begin
         r.hi = v.hi + 4'd1;
         r.lo = 4'd0;
      end else begin
         r.hi = v.hi;
         r.lo = v.lo + 4'd1;
      end
      return r;
   endfunction

endpackage

// File: rtl/bcd_time_counter_tick_gen.sv
// Prescaler: counts 0..CLK_HZ-1 while in_RUN is high and flags the terminal count
// as a one-cycle tick.
module bcd_time_counter_tick_gen #(
   parameter int unsigned CLK_HZ = 50000000,
   parameter int unsigned CNT_W  = 26
) (
   input  logic in_CLK,
   input  logic in_RST,
   input  logic in_RUN,
   output logic out_TICK
);

   localparam logic [CNT_W-1:0] CntLast = CNT_W'(CLK_HZ - 1);

   logic [CNT_W-1:0] cnt_q, cnt_d;

   always_comb begin
      out_TICK = in_RUN && (cnt_q == CntLast);
      cnt_d    = cnt_q;
      if (in_RUN) begin
         cnt_d = (cnt_q == CntLast) ? '0 : cnt_q + 1'b1;
      end
   end

   always_ff @(posedge in_CLK or posedge in_RST) begin
      if (in_RST) begin
         cnt_q <= '0;
      end else begin
         cnt_q <= cnt_d;
      end
   end

endmodule

// File: rtl/bcd_time_counter.sv
// 24-hour hh:mm:ss counter kept as six BCD digits, advanced by a 1 Hz tick and by
// single-cycle minute/hour set pulses.
module bcd_time_counter
   import bcd_time_counter_pkg::*;
#(
   parameter int unsigned CLK_HZ = 50000000,
   parameter int unsigned CNT_W  = 26
) (
   input  logic in_CLK,
   input  logic in_RST,
   input  logic in_RUN,
   input  logic in_SET_MIN,
   input  logic in_SET_HR,
   output bcd_t out_SEC_L,
   output bcd_t out_SEC_H,
   output bcd_t out_MIN_L,
   output bcd_t out_MIN_H,
   output bcd_t out_HR_L,
   output bcd_t out_HR_H,
   output logic out_TICK
);

   logic      tick;
   logic      sec_carry, min_carry;
   bcd_pair_t sec_q, sec_d, min_q, min_d, hr_q, hr_d;
   logic      tick_q, tick_d;

   bcd_time_counter_tick_gen #(
      .CLK_HZ(CLK_HZ),
      .CNT_W (CNT_W)
   ) u_tick_gen (
      .in_CLK  (in_CLK),
      .in_RST  (in_RST),
      .in_RUN  (in_RUN),
      .out_TICK(tick)
   );

   // Carries come only from the tick ripple; set pulses never carry upward, and a set
   // plus a carry in the same cycle step the field twice.
   always_comb begin
      sec_carry = tick && (sec_q.hi == SEC_MAX_H) && (sec_q.lo == DIGIT_MAX);
      min_carry = sec_carry && (min_q.hi == MIN_MAX_H) && (min_q.lo == DIGIT_MAX);

      sec_d = sec_q;
      if (tick) sec_d = bcd_inc(sec_q, SEC_MAX_H, DIGIT_MAX);

      min_d = min_q;
      if (in_SET_MIN) min_d = bcd_inc(min_d, MIN_MAX_H, DIGIT_MAX);
      if (sec_carry)  min_d = bcd_inc(min_d, MIN_MAX_H, DIGIT_MAX);

      hr_d = hr_q;
      if (in_SET_HR) hr_d = bcd_inc(hr_d, HR_MAX_H, HR_MAX_L_AT_2);
      if (min_carry) hr_d = bcd_inc(hr_d, HR_MAX_H, HR_MAX_L_AT_2);

      tick_d = tick;
   end

   always_ff @(posedge in_CLK or posedge in_RST) begin
      if (in_RST) begin
         sec_q  <= '0;
         min_q  <= '0;
         hr_q   <= '0;
         tick_q <= 1'b0;
      end else begin
         sec_q  <= sec_d;
         min_q  <= min_d;
         hr_q   <= hr_d;
         tick_q <= tick_d;
      end
   end

   assign out_SEC_L = sec_q.lo;
   assign out_SEC_H = sec_q.hi;
   assign out_MIN_L = min_q.lo;
   assign out_MIN_H = min_q.hi;
   assign out_HR_L  = hr_q.lo;
   assign out_HR_H  = hr_q.hi;
   assign out_TICK  = tick_q;

endmodule

// File: tb/tb_bcd_time_counter.sv
// Bench for bcd_time_counter: an integer h/m/s model predicts every cycle into a
// scoreboard queue; a monitor pops and compares after each rising edge.
module tb_bcd_time_counter;

   localparam int unsigned CLK_HZ = 4;
   localparam int unsigned CNT_W  = 3;

   logic       in_CLK = 1'b0;
   logic       in_RST = 1'b1;
   logic       in_RUN = 1'b0;
   logic       in_SET_MIN = 1'b0;
   logic       in_SET_HR = 1'b0;
   logic [3:0] out_SEC_L, out_SEC_H, out_MIN_L, out_MIN_H, out_HR_L, out_HR_H;
   logic       out_TICK;

   bcd_time_counter #(
      .CLK_HZ(CLK_HZ),
      .CNT_W (CNT_W)
   ) dut (
      .in_CLK    (in_CLK),
      .in_RST    (in_RST),
      .in_RUN    (in_RUN),
      .in_SET_MIN(in_SET_MIN),
      .in_SET_HR (in_SET_HR),
      .out_SEC_L (out_SEC_L),
      .out_SEC_H (out_SEC_H),
      .out_MIN_L (out_MIN_L),
      .out_MIN_H (out_MIN_H),
      .out_HR_L  (out_HR_L),
      .out_HR_H  (out_HR_H),
      .out_TICK  (out_TICK)
   );

   always #5 in_CLK = ~in_CLK;

   int unsigned n_checks = 0;
   int unsigned n_errors = 0;
   int unsigned tick_cnt = 0;

   logic [24:0] exp_q[$];

   // Reference model state: plain integers for time, prescaler phase and tick flag.
   int m_pre = 0, m_h = 0, m_m = 0, m_s = 0;
   bit m_tick = 1'b0;

   function automatic logic [24:0] pack(input int h, input int m, input int s, input bit t);
      return {4'(h / 10), 4'(h % 10), 4'(m / 10), 4'(m % 10), 4'(s / 10), 4'(s % 10), t};
   endfunction

   function automatic logic [24:0] dut_vec();
      return {out_HR_H, out_HR_L, out_MIN_H, out_MIN_L, out_SEC_H, out_SEC_L, out_TICK};
   endfunction

   task automatic check(input string name, input logic [24:0] act, input logic [24:0] req);
      n_checks++;
      if (act !== req) begin
         n_errors++;
         $display("FAIL %s: got %h (hh:mm:ss tick) required %h", name, act, req);
      end
   endtask

   task automatic check_int(input string name, input int act, input int req);
      n_checks++;
      if (act != req) begin
         n_errors++;
         $display("FAIL %s: got %0d required %0d", name, act, req);
      end
   endtask

   // Monitor: every edge the driver predicted is compared one cycle-step later.
   initial begin
      forever begin
         @(posedge in_CLK);
         #1;
         if (out_TICK === 1'b1) tick_cnt++;
         if (exp_q.size() != 0) check("scoreboard", dut_vec(), exp_q.pop_front());
      end
   end

   // One clock cycle of stimulus; called at a falling edge, returns at the next one.
   task automatic step(input bit run, input bit smin, input bit shr);
      bit tk, cm, ch;
      in_RUN     = run;
      in_SET_MIN = smin;
      in_SET_HR  = shr;
      tk = run && (m_pre == CLK_HZ - 1);
      if (run) m_pre = (m_pre + 1) % CLK_HZ;
      cm = 1'b0;
      if (tk) begin
         if (m_s == 59) begin
            m_s = 0;
            cm  = 1'b1;
         end else begin
            m_s++;
         end
      end
      ch     = cm && (m_m == 59);
      m_m    = (m_m + int'(smin) + int'(cm)) % 60;
      m_h    = (m_h + int'(shr) + int'(ch)) % 24;
      m_tick = tk;
      exp_q.push_back(pack(m_h, m_m, m_s, m_tick));
      @(negedge in_CLK);
   endtask

   task automatic apply_reset();
      in_RUN     = 1'b0;
      in_SET_MIN = 1'b0;
      in_SET_HR  = 1'b0;
      in_RST     = 1'b1;
      #1;
      check("reset_async", dut_vec(), '0);
      m_pre  = 0;
      m_h    = 0;
      m_m    = 0;
      m_s    = 0;
      m_tick = 1'b0;
      exp_q.push_back('0);
      @(negedge in_CLK);
      in_RST = 1'b0;
   endtask

   task automatic check_time(input string name, input int h, input int m, input int s,
                             input bit t);
      check(name, dut_vec(), pack(h, m, s, t));
   endtask

   // Reach a target time: seconds by running, then minutes/hours by set pulses.
   task automatic goto_time(input int h, input int m, input int s);
      int guard;
      guard = 0;
      while (m_s != s && guard < 400) begin
         step(1'b1, 1'b0, 1'b0);
         guard++;
      end
      guard = 0;
      while (m_m != m && guard < 70) begin
         step(1'b0, 1'b1, 1'b0);
         guard++;
      end
      guard = 0;
      while (m_h != h && guard < 30) begin
         step(1'b0, 1'b0, 1'b1);
         guard++;
      end
      check_int("goto_reached", m_h * 3600 + m_m * 60 + m_s, h * 3600 + m * 60 + s);
   endtask

   // Run until the internal tick lands on this step, applying the given set pulses there.
   task automatic step_on_tick(input bit smin, input bit shr);
      int guard;
      guard = 0;
      while (m_pre != CLK_HZ - 1 && guard < 2 * CLK_HZ) begin
         step(1'b1, 1'b0, 1'b0);
         guard++;
      end
      step(1'b1, smin, shr);
   endtask

   initial begin
      int t0;
      @(negedge in_CLK);
      apply_reset();

      // Reset mid-run, then first tick four cycles after release.
      repeat (10) step(1'b1, 1'b0, 1'b0);
      apply_reset();
      repeat (3) step(1'b1, 1'b0, 1'b0);
      check_time("no_tick_before_4", 0, 0, 0, 1'b0);
      step(1'b1, 1'b0, 1'b0);
      check_time("first_tick_after_reset", 0, 0, 1, 1'b1);

      // Basic count.
      apply_reset();
      t0 = int'(tick_cnt);
      repeat (40) step(1'b1, 1'b0, 1'b0);
      check_int("basic_tick_count", int'(tick_cnt) - t0, 10);
      check_time("basic_time", 0, 0, 10, 1'b1);

      // Full rollover.
      goto_time(23, 59, 59);
      step_on_tick(1'b0, 1'b0);
      check_time("full_rollover", 0, 0, 0, 1'b1);
      step(1'b0, 1'b0, 1'b0);
      check_time("tick_one_cycle", 0, 0, 0, 1'b0);

      // Set wraps without carry.
      goto_time(5, 59, 30);
      step(1'b0, 1'b1, 1'b0);
      check_time("set_min_wrap", 5, 0, 30, 1'b0);
      goto_time(23, 0, 30);
      step(1'b0, 1'b0, 1'b1);
      check_time("set_hr_wrap", 0, 0, 30, 1'b0);

      // Collisions of tick carries with set pulses.
      goto_time(10, 14, 59);
      step_on_tick(1'b1, 1'b0);
      check_time("collide_min", 10, 16, 0, 1'b1);
      goto_time(22, 59, 59);
      step_on_tick(1'b0, 1'b1);
      check_time("collide_hr", 0, 0, 0, 1'b1);

      // Freeze, then set while frozen.
      goto_time(12, 34, 56);
      step(1'b0, 1'b0, 1'b0);
      t0 = int'(tick_cnt);
      repeat (20) step(1'b0, 1'b0, 1'b0);
      check_int("freeze_no_ticks", int'(tick_cnt) - t0, 0);
      check_time("freeze_time", 12, 34, 56, 1'b0);
      step(1'b0, 1'b0, 1'b1);
      check_time("set_while_frozen", 13, 34, 56, 1'b0);

      // Randomised traffic, including occasional resets.
      for (int i = 0; i < 3000; i++) begin
         if ($urandom_range(0, 399) == 0) begin
            apply_reset();
         end else begin
            step($urandom_range(0, 9) != 0, $urandom_range(0, 11) == 0,
                 $urandom_range(0, 15) == 0);
         end
      end

      step(1'b0, 1'b0, 1'b0);
      check_int("scoreboard_drained", exp_q.size(), 0);
      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

   initial begin
      #2000000;
      $display("FAIL watchdog: simulation did not complete, got timeout required finish");
      $fatal(1);
   end

endmodule

// File: doc/bcd_time_counter.md
Name: bcd_time_counter

Overview:
- Sequential timekeeping core of the digital clock. Divides the board clock to a 1 Hz tick and keeps hours:minutes:seconds in 24-hour format as six BCD digits.
- Also accepts single-cycle set pulses for minutes and hours.
- Each output digit drives one 4-bit-to-7-segment decoder instance directly downstream; only the values 0-9 ever appear on a digit.

Parameters:
- CLK_HZ, 50000000, input clock frequency; the prescaler wraps every CLK_HZ cycles. Must be >= 2.
- CNT_W, 26, prescaler counter width; must satisfy 2^CNT_W >= CLK_HZ.

Ports:
- in_CLK  input  1  system clock; all state updates on its rising edge.
- in_RST  input  1  reset, asynchronous, active-high.
- in_RUN  input  1  1 = time advances on each tick; 0 = prescaler and time frozen.
- in_SET_MIN  input  1  single-cycle pulse (already debounced); increments minutes.
- in_SET_HR  input  1  single-cycle pulse (already debounced); increments hours.
- out_SEC_L  output  4  seconds units, BCD 0-9.
- out_SEC_H  output  4  seconds tens, BCD 0-5.
- out_MIN_L  output  4  minutes units, BCD 0-9.
- out_MIN_H  output  4  minutes tens, BCD 0-5.
- out_HR_L  output  4  hours units, BCD 0-9 (0-3 when out_HR_H=2).
- out_HR_H  output  4  hours tens, BCD 0-2.
- out_TICK  output  1  one-cycle pulse, high in the cycle the time advanced by 1 s.

Behaviour:
- Reset: in_RST=1 asynchronously clears all six digits to 0, the prescaler to 0 and out_TICK to 0; time reads 00:00:00. Reset asserted mid-count or mid-carry discards all state. Counting resumes from prescaler 0 on the first edge after deassertion.
- Prescaler:
  - When in_RUN=1, it counts 0..CLK_HZ-1 and wraps.
  - The internal tick is high in the cycle the prescaler equals CLK_HZ-1.
  - When in_RUN=0, the prescaler holds and no tick occurs.
- Tick advance, on the edge where tick=1:
  - Seconds increment with ripple carry: SEC_L 9->0 carries into SEC_H; SEC_H 5 with SEC_L 9 ->00 carries into minutes.
  - Minutes follow the same 59->00 rule and carry into hours.
  - Hours wrap 23->00.
  - Full rollover: 23:59:59 -> 00:00:00 in a single edge.
  - Outputs are registered and change on that same edge; out_TICK is high for exactly the following cycle (registered, 1-cycle latency from the internal tick).
- Set pulses:
  - in_SET_MIN: minutes +1, wraps 59->00 with NO carry into hours; seconds unaffected.
  - in_SET_HR: hours +1, wraps 23->00; minutes and seconds unaffected.
  - Set pulses act regardless of in_RUN.
- Simultaneous events: each field updates independently from its own rule.
  - Minutes field, with SET_MIN and a seconds carry in the same cycle: minutes += 2 modulo 60, still with no carry into hours.
  - Hours field, with SET_HR and a minutes carry in the same cycle: hours += 2 modulo 24.
  - SET_MIN and SET_HR together: both fields step once.
  - A tick in the same cycle as a set pulse still advances seconds normally.
- Arithmetic: digit-wise BCD only, never binary-to-BCD conversion. No digit ever leaves its legal range, including at every wrap.
- in_SET_* held high for multiple cycles increments once per cycle; edge detection is upstream and out of scope.

Decomposition:
- Shared package/header: constants SEC_MAX_H=5, MIN_MAX_H=5, HR_MAX_H=2, HR_MAX_L_AT_2=3, DIGIT_MAX=9; a 4-bit BCD digit type.
- Sub-module tick_gen: holds the prescaler and the in_RUN gate, parameterised by CLK_HZ and CNT_W, and outputs a 1-cycle tick.
- bcd_time_counter instantiates tick_gen and contains the three modulo fields: mod-60 seconds, mod-60 minutes, mod-24 hours. The hour field requires a distinct wrap check: tens=2 and units=3.

Test Plan (CLK_HZ=4 for simulation):
- Reset mid-run: run 10 cycles, pulse in_RST asynchronously between edges -> all outputs 0 immediately; out_TICK=0; first tick arrives 4 cycles after deassertion.
- Basic count: in_RUN=1 for 40 cycles -> exactly 10 out_TICK pulses, 4 cycles apart; time 00:00:10 (SEC_H=1, SEC_L=0).
- Full rollover: load 23:59:59 via set pulses and ticks, then one tick -> 00:00:00 on the same edge, and out_TICK=1 on the next cycle.
- Set wrap, no carry: at 05:59:30 pulse in_SET_MIN -> 05:00:30; at 23:xx pulse in_SET_HR -> 00:xx.
- Collision: at 10:14:59, tick coincides with in_SET_MIN -> 10:16:00. At 22:59:59, tick coincides with in_SET_HR -> 00:00:00 (hours 22+1+1 mod 24).
- Freeze: in_RUN=0 for 20 cycles at 12:34:56 -> no out_TICK pulses and the time is unchanged. A set pulse applied while frozen still works: in_SET_HR -> 13:34:56.
